regfile_wb_sched: RTL and testbench

- Schedules the single write port of the core's register file among the in-order pipeline writeback and num_req_p long-latency writeback sources, such as remote-load returns and iterative div/fdiv.
- The pipeline has fixed priority. Long-latency sources share the remaining slots round-robin.
- A starvation counter forces a one-cycle pipeline bubble so that long-latency writebacks always drain.
- Sits between the exe/mem writeback stage and the regfile write port.

---
 rtl/vanilla_wb_pkg.sv | 19 +
 rtl/bsg_arb_round_robin.sv | 68 ++++++
 rtl/regfile_wb_sched_chk.sv | 25 ++
 rtl/regfile_wb_sched.sv | 115 +++++++++++
 tb/tb_regfile_wb_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vanilla_wb_pkg.sv
// Shared writeback types, defaults and width helpers for the register-file
// write-port scheduler.
`define DECLARE_REGFILE_WB_REQ_S(data_width_mp, addr_width_mp) \
   typedef struct packed { \
      logic [addr_width_mp-1:0] addr; \
      logic [data_width_mp-1:0] data; \
   } regfile_wb_req_s

package vanilla_wb_pkg;

   localparam int wb_starve_limit_default_gp = 4;
   localparam int wb_starve_cnt_width_gp     = 8;

   // Never returns zero, so a one-entry vector still gets a 1-bit index.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves to winner+1 whenever the grant is consumed.
module bsg_arb_round_robin
   import vanilla_wb_pkg::*;
#(
   parameter int width_p = 2,
   localparam int tag_width_lp = safe_clog2(width_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    grants_en_i,
   input  logic [width_p-1:0]      reqs_i,
   output logic [width_p-1:0]      grants_o,
   output logic                    v_o,
   output logic [tag_width_lp-1:0] tag_o,
   input  logic                    yumi_i
);

   logic [tag_width_lp-1:0] ptr_r;
   logic [tag_width_lp-1:0] ptr_nxt_s;
   logic [tag_width_lp-1:0] idx_s;
   int                      sum_s;

   // Scan requesters starting at the pointer, wrapping at width_p.
   always_comb begin
      v_o       = 1'b0;
      tag_o     = '0;
      idx_s     = '0;
      sum_s     = 0;
      grants_o  = '0;
      ptr_nxt_s = '0;
      for (int k = 0; k < width_p; k++) begin
         sum_s = int'(ptr_r) + k;
         if (sum_s >= width_p) begin
            sum_s = sum_s - width_p;
         end else begin
            sum_s = sum_s;
         end
         idx_s = tag_width_lp'(sum_s);
         if (!v_o && reqs_i[idx_s]) begin
            v_o   = 1'b1;
            tag_o = idx_s;
         end else begin
            v_o   = v_o;
         end
      end
      if (v_o && grants_en_i) begin
         grants_o[tag_o] = 1'b1;
      end else begin
         grants_o = '0;
      end
      if (int'(tag_o) == width_p - 1) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = tag_o + tag_width_lp'(1);
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_r <= '0;
      end else if (yumi_i) begin
         ptr_r <= ptr_nxt_s;
      end
   end

endmodule

// File: rtl/regfile_wb_sched_chk.sv
// Protocol properties of the writeback scheduler, bound into the top.
module regfile_wb_sched_chk #(
   parameter int num_req_p = 2
) (
   input logic                 clk_i,
   input logic                 reset_i,
   input logic                 pipe_v_i,
   input logic                 stall_pipe_o,
   input logic [num_req_p-1:0] req_v_i,
   input logic [num_req_p-1:0] req_yumi_o
);

   a_no_pipe_in_stall: assert property (@(posedge clk_i) disable iff (reset_i)
      stall_pipe_o |-> !pipe_v_i);

   a_stall_single: assert property (@(posedge clk_i) disable iff (reset_i)
      stall_pipe_o |=> !stall_pipe_o);

   a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
      $onehot0(req_yumi_o));

   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
      (req_yumi_o & ~req_v_i) == '0);

endmodule

// File: rtl/regfile_wb_sched.sv
// Single regfile write-port scheduler: pipeline has fixed priority, long-latency
// sources share leftover slots round-robin, starvation forces a pipeline bubble.
module regfile_wb_sched
   import vanilla_wb_pkg::*;
#(
   parameter int width_p           = 32,
   parameter int els_p             = 32,
   parameter int num_req_p         = 2,
   parameter int starve_limit_p    = wb_starve_limit_default_gp,
   parameter int x0_tied_to_zero_p = 0,
   localparam int addr_width_lp    = safe_clog2(els_p),
   localparam int tag_width_lp     = safe_clog2(num_req_p)
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   pipe_v_i,
   input  logic [addr_width_lp-1:0]               pipe_addr_i,
   input  logic [width_p-1:0]                     pipe_data_i,
   input  logic [num_req_p-1:0]                   req_v_i,
   input  logic [num_req_p-1:0][addr_width_lp-1:0] req_addr_i,
   input  logic [num_req_p-1:0][width_p-1:0]      req_data_i,
   output logic [num_req_p-1:0]                   req_yumi_o,
   output logic                                   stall_pipe_o,
   output logic                                   w_v_o,
   output logic [addr_width_lp-1:0]               w_addr_o,
   output logic [width_p-1:0]                     w_data_o
);

   `DECLARE_REGFILE_WB_REQ_S(width_p, addr_width_lp);

   logic [num_req_p-1:0]              grants_s;
   logic                              arb_v_s;
   logic [tag_width_lp-1:0]           grant_tag_s;
   regfile_wb_req_s                   sel_s;
   logic                              src_v_s;
   logic                              drop_s;
   logic [wb_starve_cnt_width_gp-1:0] starve_cnt_r;
   logic [wb_starve_cnt_width_gp-1:0] starve_cnt_inc_s;
   logic                              stall_r;

   // Requesters are only granted when the pipeline leaves the port free.
   bsg_arb_round_robin #(.width_p(num_req_p)) arb (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .grants_en_i (~pipe_v_i & ~reset_i),
      .reqs_i      (req_v_i),
      .grants_o    (grants_s),
      .v_o         (arb_v_s),
      .tag_o       (grant_tag_s),
      .yumi_i      (|grants_s)
   );

   // Select the port owner and filter writes aimed at a hardwired x0.
   always_comb begin
      sel_s   = '0;
      src_v_s = 1'b0;
      drop_s  = 1'b0;
      if (pipe_v_i) begin
         sel_s.addr = pipe_addr_i;
         sel_s.data = pipe_data_i;
         src_v_s    = 1'b1;
      end else if (arb_v_s) begin
         sel_s.addr = req_addr_i[grant_tag_s];
         sel_s.data = req_data_i[grant_tag_s];
         src_v_s    = 1'b1;
      end else begin
         sel_s   = '0;
         src_v_s = 1'b0;
      end
      if ((x0_tied_to_zero_p != 0) && (sel_s.addr == '0)) begin
         drop_s = 1'b1;
      end else begin
         drop_s = 1'b0;
      end
   end

   assign starve_cnt_inc_s = starve_cnt_r + 8'd1;

   // Starvation counter and one-shot stall request.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         starve_cnt_r <= '0;
         stall_r      <= 1'b0;
      end else if (|grants_s) begin
         starve_cnt_r <= '0;
         stall_r      <= 1'b0;
      end else if (arb_v_s && pipe_v_i) begin
         if (starve_cnt_inc_s == 8'(starve_limit_p)) begin
            starve_cnt_r <= '0;
            stall_r      <= ~stall_r;
         end else begin
            starve_cnt_r <= starve_cnt_inc_s;
            stall_r      <= 1'b0;
         end
      end else begin
         stall_r <= 1'b0;
      end
   end

   assign req_yumi_o   = grants_s;
   assign stall_pipe_o = stall_r;
   assign w_v_o        = src_v_s & ~drop_s & ~reset_i;
   assign w_addr_o     = sel_s.addr;
   assign w_data_o     = sel_s.data;

   regfile_wb_sched_chk #(.num_req_p(num_req_p)) chk (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .pipe_v_i     (pipe_v_i),
      .stall_pipe_o (stall_pipe_o),
      .req_v_i      (req_v_i),
      .req_yumi_o   (req_yumi_o)
   );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: reset-relative vector table, hand sequences for
// round-robin / starvation / reset, then random traffic against a queue model.
module tb_regfile_wb_sched;

   localparam int W = 32;
   localparam int E = 32;
   localparam int N = 2;
   localparam int L = 4;
   localparam int AW = 5;

   logic                 clk_i = 1'b0;
   logic                 reset_i;
   logic                 pipe_v_i;
   logic [AW-1:0]        pipe_addr_i;
   logic [W-1:0]         pipe_data_i;
   logic [N-1:0]         req_v_i;
   logic [N-1:0][AW-1:0] req_addr_i;
   logic [N-1:0][W-1:0]  req_data_i;
   logic [N-1:0]         req_yumi_o;
   logic                 stall_pipe_o;
   logic                 w_v_o;
   logic [AW-1:0]        w_addr_o;
   logic [W-1:0]         w_data_o;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   regfile_wb_sched #(
      .width_p(W), .els_p(E), .num_req_p(N), .starve_limit_p(L), .x0_tied_to_zero_p(1)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .pipe_v_i(pipe_v_i), .pipe_addr_i(pipe_addr_i),
      .pipe_data_i(pipe_data_i), .req_v_i(req_v_i), .req_addr_i(req_addr_i),
      .req_data_i(req_data_i), .req_yumi_o(req_yumi_o), .stall_pipe_o(stall_pipe_o),
      .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o)
   );

   typedef struct {
      logic        pv;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic [1:0]  rv;
      logic [4:0]  ra0, ra1;
      logic [31:0] rd0, rd1;
      logic        ewv;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic [1:0]  ey;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      pipe_v_i = 1'b0; pipe_addr_i = '0; pipe_data_i = '0;
      req_v_i = '0; req_addr_i = '0; req_data_i = '0;
   endtask

   task automatic do_reset();
      idle();
      reset_i = 1'b1;
      pipe_v_i = 1'b1; pipe_addr_i = 5'd9; pipe_data_i = 32'h1;
      req_v_i = 2'b11; req_addr_i[0] = 5'd3; req_addr_i[1] = 5'd7;
      #1;
      check("rst_w_v", 64'(w_v_o), 64'(0));
      check("rst_yumi", 64'(req_yumi_o), 64'(0));
      cyc();
      reset_i = 1'b0;
      idle();
   endtask

   task automatic denied(input int n, input string nm);
      for (int k = 0; k < n; k++) begin
         pipe_v_i = 1'b1; pipe_addr_i = 5'd4; pipe_data_i = 32'h4444;
         req_v_i = 2'b01; req_addr_i[0] = 5'd9; req_data_i[0] = 32'h9999;
         #1;
         check(nm, 64'(stall_pipe_o), 64'(0));
         check({nm, "_yumi"}, 64'(req_yumi_o), 64'(0));
         cyc();
      end
   endtask

   task automatic expect_stall_drain(input string nm);
      pipe_v_i = 1'b0;
      req_v_i = 2'b01; req_addr_i[0] = 5'd9; req_data_i[0] = 32'h9999;
      #1;
      check({nm, "_stall"}, 64'(stall_pipe_o), 64'(1));
      check({nm, "_yumi"}, 64'(req_yumi_o), 64'(1));
      check({nm, "_w_v"}, 64'(w_v_o), 64'(1));
      check({nm, "_w_addr"}, 64'(w_addr_o), 64'(9));
      cyc();
      idle();
      #1;
      check({nm, "_stall_after"}, 64'(stall_pipe_o), 64'(0));
   endtask

   // Reference model state.
   bit          pend[N];
   logic [4:0]  paddr[N];
   logic [31:0] pdata[N];
   int          m_cnt, m_ptr, win;
   bit          m_stall, anyp, stall_next;
   logic        ewv;
   logic [4:0]  ea;
   logic [31:0] ed;
   logic [1:0]  ey;

   initial begin
      reset_i = 1'b1;
      idle();

      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 2'b00};
      tbl[1] = '{1'b1, 5'd12, 32'h1234, 2'b11, 5'd3, 5'd7, 32'hA, 32'hB, 1'b1, 5'd12, 32'h1234, 2'b00};
      tbl[2] = '{1'b0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd7, 32'hAAAA, 32'hBBBB, 1'b1, 5'd3, 32'hAAAA, 2'b01};
      tbl[3] = '{1'b0, 5'd0, 32'h0, 2'b10, 5'd3, 5'd7, 32'hAAAA, 32'hBBBB, 1'b1, 5'd7, 32'hBBBB, 2'b10};
      tbl[4] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd7, 32'hAAAA, 32'hBBBB, 1'b1, 5'd3, 32'hAAAA, 2'b01};
      tbl[5] = '{1'b0, 5'd0, 32'h0, 2'b10, 5'd3, 5'd0, 32'hAAAA, 32'hBBBB, 1'b0, 5'd0, 32'h0, 2'b10};
      tbl[6] = '{1'b1, 5'd0, 32'h77, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 2'b00};
      tbl[7] = '{1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 2'b00};

      for (int i = 0; i < 8; i++) begin
         do_reset();
         check("post_rst_stall", 64'(stall_pipe_o), 64'(0));
         pipe_v_i = tbl[i].pv; pipe_addr_i = tbl[i].pa; pipe_data_i = tbl[i].pd;
         req_v_i = tbl[i].rv;
         req_addr_i[0] = tbl[i].ra0; req_addr_i[1] = tbl[i].ra1;
         req_data_i[0] = tbl[i].rd0; req_data_i[1] = tbl[i].rd1;
         #1;
         check($sformatf("vec%0d_w_v", i), 64'(w_v_o), 64'(tbl[i].ewv));
         check($sformatf("vec%0d_yumi", i), 64'(req_yumi_o), 64'(tbl[i].ey));
         if (tbl[i].ewv) begin
            check($sformatf("vec%0d_w_addr", i), 64'(w_addr_o), 64'(tbl[i].ea));
            check($sformatf("vec%0d_w_data", i), 64'(w_data_o), 64'(tbl[i].ed));
         end
      end

      // Round-robin alternation with both requesters held valid.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req_v_i = 2'b11; req_addr_i[0] = 5'd3; req_addr_i[1] = 5'd7;
         req_data_i[0] = 32'h30; req_data_i[1] = 32'h70;
         #1;
         check($sformatf("rr%0d_yumi", k), 64'(req_yumi_o), (k % 2 == 0) ? 64'(1) : 64'(2));
         check($sformatf("rr%0d_w_addr", k), 64'(w_addr_o), (k % 2 == 0) ? 64'(3) : 64'(7));
         cyc();
      end

      // Four denied cycles produce exactly one stall cycle that drains req0.
      do_reset();
      denied(4, "starve");
      expect_stall_drain("starve_drain");

      // A yumi in between restarts the starvation count.
      do_reset();
      denied(2, "pre_yumi");
      pipe_v_i = 1'b0; req_v_i = 2'b01; req_addr_i[0] = 5'd9;
      #1;
      check("mid_yumi", 64'(req_yumi_o), 64'(1));
      cyc();
      denied(4, "post_yumi");
      expect_stall_drain("post_yumi_drain");

      // Reset with the counter at 3 discards the progress.
      do_reset();
      denied(3, "pre_rst");
      reset_i = 1'b1;
      pipe_v_i = 1'b1; req_v_i = 2'b01;
      #1;
      check("midrst_yumi", 64'(req_yumi_o), 64'(0));
      cyc();
      reset_i = 1'b0;
      denied(4, "post_rst");
      expect_stall_drain("post_rst_drain");

      // Random traffic against the reference model.
      do_reset();
      m_cnt = 0; m_ptr = 0; m_stall = 1'b0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]  = 1'b1;
               paddr[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               pdata[i] = $urandom;
            end
            req_v_i[i] = pend[i]; req_addr_i[i] = paddr[i]; req_data_i[i] = pdata[i];
         end
         pipe_v_i    = m_stall ? 1'b0 : ($urandom_range(0, 99) < 65);
         pipe_addr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         pipe_data_i = $urandom;
         #1;

         anyp = 1'b0;
         for (int i = 0; i < N; i++) anyp = anyp | pend[i];
         win = -1; ey = '0; ea = '0; ed = '0; ewv = 1'b0;
         if (pipe_v_i) begin
            ea = pipe_addr_i; ed = pipe_data_i; ewv = (pipe_addr_i != 5'd0);
         end else begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) begin
               ey[win] = 1'b1; ea = paddr[win]; ed = pdata[win]; ewv = (paddr[win] != 5'd0);
            end
         end

         check("rnd_stall", 64'(stall_pipe_o), 64'(m_stall));
         check("rnd_yumi", 64'(req_yumi_o), 64'(ey));
         check("rnd_w_v", 64'(w_v_o), 64'(ewv));
         if (ewv) begin
            check("rnd_w_addr", 64'(w_addr_o), 64'(ea));
            check("rnd_w_data", 64'(w_data_o), 64'(ed));
         end

         stall_next = 1'b0;
         if (win >= 0) begin
            m_cnt = 0; m_ptr = (win + 1) % N; pend[win] = 1'b0;
         end else if (anyp && pipe_v_i) begin
            m_cnt++;
            if (m_cnt == L) begin
               m_cnt = 0; stall_next = 1'b1;
            end
         end
         m_stall = stall_next;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
